prim_lc_sender_filt: RTL and testbench



---
 rtl/prim_lc_sender_filt.sv | 120 ++++++++++++
 tb/tb_prim_lc_sender_filt.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_lc_sender_filt.sv
// Multi-channel life cycle sender: glitch-filters each lc_tx_t channel before asserting On.
// Optional macro PRIM_LC_SENDER_FILT_STICKY_EN latches a channel Off after its first On->Off drop.
module prim_lc_sender_filt #(
    parameter int unsigned NumCh        = 1,
    parameter int unsigned FilterCycles = 4,
    parameter int unsigned AsyncOn      = 0,
    localparam int unsigned TxWidth     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumCh*TxWidth-1:0] lc_en_i,
    input  logic [NumCh-1:0]         err_clr_i,
    output logic [NumCh*TxWidth-1:0] lc_en_o,
    output logic [NumCh-1:0]         err_o
);

    localparam logic [TxWidth-1:0] LcOn  = TxWidth'(4'b1010);
    localparam logic [TxWidth-1:0] LcOff = TxWidth'(4'b0101);

    localparam int unsigned CntW  = $clog2(FilterCycles + 1);
    localparam int unsigned CntW1 = CntW + 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(FilterCycles);
    localparam logic [CntW:0]   FiltThr = CntW1'(FilterCycles);

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        logic [TxWidth-1:0] in_raw;
        logic [TxWidth-1:0] s;

        assign in_raw = lc_en_i[c*TxWidth +: TxWidth];

        if (AsyncOn != 0) begin : g_sync
            logic [TxWidth-1:0] sync1_d, sync1_q;
            logic [TxWidth-1:0] sync2_d, sync2_q;

            always_comb begin
                sync1_d = in_raw;
                sync2_d = sync1_q;
            end

            // Two-stage synchroniser, resets to Off so a reset channel never looks enabled.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync1_q <= LcOff;
                    sync2_q <= LcOff;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                end
            end

            assign s = sync2_q;
        end else begin : g_nosync
            assign s = in_raw;
        end

        logic [CntW-1:0]    cnt_d, cnt_q;
        logic [TxWidth-1:0] out_d, out_q;
        logic               err_d, err_q;
        logic               s_on;
        logic               s_valid;
        logic [CntW:0]      cnt_inc;
        logic [TxWidth-1:0] out_raw;

        always_comb begin
            s_on    = (s == LcOn);
            s_valid = s_on || (s == LcOff);
            cnt_inc = {1'b0, cnt_q} + CntW1'(1);
            cnt_d   = '0;
            out_raw = LcOff;

            if (s_on) begin
                cnt_d = (cnt_q == CntMax) ? CntMax : cnt_inc[CntW-1:0];
                if (cnt_inc >= FiltThr) begin
                    out_raw = LcOn;
                end
            end

            // Set dominates clear so a simultaneous bad sample is never lost.
            err_d = !s_valid || (err_q && !err_clr_i[c]);
        end

`ifdef PRIM_LC_SENDER_FILT_STICKY_EN
        logic dead_d, dead_q;

        always_comb begin
            dead_d = dead_q || ((out_q == LcOn) && (out_raw == LcOff));
            out_d  = dead_q ? LcOff : out_raw;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dead_q <= 1'b0;
            end else begin
                dead_q <= dead_d;
            end
        end
`else
        always_comb begin
            out_d = out_raw;
        end
`endif

        // Output and counter held in dedicated flops so the encoding stays as written.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                out_q <= LcOff;
                err_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                out_q <= out_d;
                err_q <= err_d;
            end
        end

        assign lc_en_o[c*TxWidth +: TxWidth] = out_q;
        assign err_o[c]                      = err_q;
    end

endmodule

// File: tb/tb_prim_lc_sender_filt.sv
// Directed bench for prim_lc_sender_filt: a 3-channel synchronous instance and a 1-channel async instance.
module tb_prim_lc_sender_filt;

    localparam logic [3:0] ON  = 4'b1010;
    localparam logic [3:0] OFF = 4'b0101;

`ifdef PRIM_LC_SENDER_FILT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] a_in;
    logic [11:0] a_out;
    logic [2:0]  a_clr;
    logic [2:0]  a_err;
    logic [3:0]  b_in;
    logic [3:0]  b_out;
    logic [0:0]  b_clr;
    logic [0:0]  b_err;

    int total = 0;
    int bad   = 0;

    prim_lc_sender_filt #(.NumCh(3), .FilterCycles(4), .AsyncOn(0)) dut_a (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .lc_en_i  (a_in),
        .err_clr_i(a_clr),
        .lc_en_o  (a_out),
        .err_o    (a_err)
    );

    prim_lc_sender_filt #(.NumCh(1), .FilterCycles(1), .AsyncOn(1)) dut_b (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .lc_en_i  (b_in),
        .err_clr_i(b_clr),
        .lc_en_o  (b_out),
        .err_o    (b_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        a_in  = {OFF, OFF, OFF};
        a_clr = 3'b000;
        b_in  = OFF;
        b_clr = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        rst_n = 1'b0;
        tick();
        total++;
        if (a_out !== {OFF, OFF, OFF}) begin
            bad++;
            $display("FAIL reset_a_out got=%h want=%h", a_out, {OFF, OFF, OFF});
        end
        total++;
        if (a_err !== 3'b000 || b_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b/%b want=000/0", a_err, b_err);
        end
        total++;
        if (b_out !== OFF) begin
            bad++;
            $display("FAIL reset_b_out got=%h want=%h", b_out, OFF);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_on_latency;
        logic [11:0] exp;
        do_reset();
        a_in[3:0] = ON;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = {OFF, OFF, (i >= 3) ? ON : OFF};
            total++;
            if (a_out !== exp) begin
                bad++;
                $display("FAIL on_latency edge=%0d got=%h want=%h", i, a_out, exp);
            end
        end
        a_in[3:0] = OFF;
        tick();
        total++;
        if (a_out !== {OFF, OFF, OFF}) begin
            bad++;
            $display("FAIL off_latency got=%h want=%h", a_out, {OFF, OFF, OFF});
        end
    endtask

    task automatic test_glitch;
        logic [3:0] exp;
        do_reset();
        a_in[3:0] = ON;
        for (int i = 0; i < 3; i++) tick();
        a_in[3:0] = OFF;
        tick();
        a_in[3:0] = ON;
        for (int i = 0; i < 14; i++) begin
            tick();
            exp = (i >= 3) ? ON : OFF;
            total++;
            if (a_out[3:0] !== exp) begin
                bad++;
                $display("FAIL glitch_restart edge=%0d got=%h want=%h", i, a_out[3:0], exp);
            end
        end
    endtask

    task automatic test_invalid;
        do_reset();
        a_in[3:0] = ON;
        for (int i = 0; i < 4; i++) tick();
        a_in[3:0] = 4'b1111;
        tick();
        total++;
        if (a_out[3:0] !== OFF || a_err !== 3'b001) begin
            bad++;
            $display("FAIL invalid_set got=%h/%b want=%h/001", a_out[3:0], a_err, OFF);
        end
        a_in[3:0] = ON;
        tick();
        total++;
        if (a_err !== 3'b001) begin
            bad++;
            $display("FAIL err_sticky got=%b want=001", a_err);
        end
        a_clr[0] = 1'b1;
        tick();
        total++;
        if (a_err !== 3'b000) begin
            bad++;
            $display("FAIL err_clear got=%b want=000", a_err);
        end
        a_in[3:0] = 4'b1111;
        tick();
        total++;
        if (a_err !== 3'b001) begin
            bad++;
            $display("FAIL set_beats_clear got=%b want=001", a_err);
        end
        a_in[3:0] = ON;
        a_clr[0]  = 1'b0;
        tick();
        total++;
        if (a_err !== 3'b001) begin
            bad++;
            $display("FAIL err_hold got=%b want=001", a_err);
        end
        a_clr[0] = 1'b1;
        tick();
        total++;
        if (a_err !== 3'b000) begin
            bad++;
            $display("FAIL err_clear2 got=%b want=000", a_err);
        end
        a_clr[0] = 1'b0;
    endtask

    task automatic test_multi_ch;
        logic [11:0] exp;
        do_reset();
        a_in = {OFF, ON, OFF};
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = {OFF, (i >= 3) ? ON : OFF, OFF};
            total++;
            if (a_out !== exp || a_err !== 3'b000) begin
                bad++;
                $display("FAIL multi_ch edge=%0d got=%h/%b want=%h/000", i, a_out, a_err, exp);
            end
        end
        a_in[11:8] = 4'b0000;
        tick();
        total++;
        if (a_out !== {OFF, ON, OFF} || a_err !== 3'b100) begin
            bad++;
            $display("FAIL multi_glitch got=%h/%b want=%h/100", a_out, a_err, {OFF, ON, OFF});
        end
        a_in[11:8] = OFF;
        tick();
        total++;
        if (a_out !== {OFF, ON, OFF} || a_err !== 3'b100) begin
            bad++;
            $display("FAIL multi_after got=%h/%b want=%h/100", a_out, a_err, {OFF, ON, OFF});
        end
    endtask

    task automatic test_async;
        logic [3:0] exp;
        do_reset();
        b_in = ON;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = (i >= 2) ? ON : OFF;
            total++;
            if (b_out !== exp) begin
                bad++;
                $display("FAIL async_latency edge=%0d got=%h want=%h", i, b_out, exp);
            end
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (b_out !== OFF || b_err !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got=%h/%b want=%h/0", b_out, b_err, OFF);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = (i >= 2) ? ON : OFF;
            total++;
            if (b_out !== exp) begin
                bad++;
                $display("FAIL post_reset edge=%0d got=%h want=%h", i, b_out, exp);
            end
        end
    endtask

    task automatic test_sticky;
        logic [3:0] exp;
        do_reset();
        b_in = ON;
        for (int i = 0; i < 3; i++) tick();
        b_in = OFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = (i >= 2) ? OFF : ON;
            total++;
            if (b_out !== exp) begin
                bad++;
                $display("FAIL drop edge=%0d got=%h want=%h", i, b_out, exp);
            end
        end
        b_in = ON;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = (i >= 2 && !STICKY) ? ON : OFF;
            total++;
            if (b_out !== exp) begin
                bad++;
                $display("FAIL reenable edge=%0d got=%h want=%h", i, b_out, exp);
            end
        end
        do_reset();
        b_in = ON;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (b_out !== ON) begin
            bad++;
            $display("FAIL reset_revive got=%h want=%h", b_out, ON);
        end
    endtask

    initial begin
        a_in  = {OFF, OFF, OFF};
        a_clr = 3'b000;
        b_in  = OFF;
        b_clr = 1'b0;
        test_reset();
        test_on_latency();
        test_glitch();
        test_invalid();
        test_multi_ch();
        test_async();
        test_sticky();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
